// File: rtl/toy_lsu_dtcm_ctrl.sv
// DTCM access controller: turns LSU requests into 1-cycle SRAM accesses and returns one
// in-order response per accepted request. rst_n is a synchronous, active-HIGH reset.
module toy_lsu_dtcm_ctrl #(
    parameter int          ADDR_W     = 32,
    parameter int          TAG_W      = 6,
    parameter int          SRAM_AW    = 12,
    parameter logic [31:0] DTCM_BASE  = 32'h0010_0000,
    parameter int          RESP_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               s_vld,
    output logic               s_rdy,
    input  logic [ADDR_W-1:0]  s_addr,
    input  logic               s_store,
    input  logic [1:0]         s_size,
    input  logic               s_unsigned,
    input  logic [31:0]        s_wdata,
    input  logic [TAG_W-1:0]   s_tag,
    output logic               sram_en,
    output logic               sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [3:0]         sram_wbe,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata,
    output logic               m_vld,
    input  logic               m_rdy,
    output logic [TAG_W-1:0]   m_tag,
    output logic [31:0]        m_data,
    output logic               m_err
);

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int PTR_W = $clog2(RESP_DEPTH);

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ---------------- S0: request decode and SRAM drive ----------------
    size_e             s0_size;
    logic [1:0]        s0_off;
    logic              s0_err;
    logic              acc;
    logic [ADDR_W-1:0] rel_addr;
    logic              rel_addr_unused;

    logic [CNT_W-1:0]  cnt;
    logic              s1_vld;
    logic [CNT_W:0]    credit_used;

    assign s0_size = size_e'(s_size);
    assign s0_off  = s_addr[1:0];
    assign s0_err  = (s0_size == SZ_ILL)
                   | ((s0_size == SZ_HALF) & s0_off[0])
                   | ((s0_size == SZ_WORD) & (s0_off != 2'b00));

    // The queued entries plus the one in S1 each own a FIFO slot; a same-cycle pop is not credited.
    assign credit_used = {1'b0, cnt} + {{CNT_W{1'b0}}, s1_vld};
    assign s_rdy       = !rst_n && !flush && (credit_used < (CNT_W + 1)'(RESP_DEPTH));
    assign acc         = s_vld && s_rdy;

    assign rel_addr        = s_addr - ADDR_W'(DTCM_BASE);
    assign sram_addr       = rel_addr[SRAM_AW+1:2];
    assign rel_addr_unused = ^{rel_addr[ADDR_W-1:SRAM_AW+2], rel_addr[1:0]};

    assign sram_en = acc && !s0_err;
    assign sram_we = s_store;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        sram_wbe   = 4'b0000;
        sram_wdata = s_wdata;
        case (s0_size)
            SZ_BYTE: begin
                sram_wbe   = 4'b0001 << s0_off;
                sram_wdata = {4{s_wdata[7:0]}};
            end
            SZ_HALF: begin
                sram_wbe   = 4'b0011 << s0_off;
                sram_wdata = {2{s_wdata[15:0]}};
            end
            SZ_WORD: sram_wbe = 4'b1111;
            default: sram_wbe = 4'b0000;
        endcase
    end

    // ---------------- S1: capture request, align read data ----------------
    logic [TAG_W-1:0] s1_tag;
    size_e            s1_size;
    logic             s1_unsigned;
    logic [1:0]       s1_off;
    logic             s1_store;
    logic             s1_err;
    logic [7:0]       s1_byte;
    logic [15:0]      s1_half;
    logic [31:0]      s1_data;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_n || flush) begin
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= acc;
        end
    end

    // NOTE: payload and FIFO storage carry no reset; they are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (acc) begin
            s1_tag      <= s_tag;
            s1_size     <= s0_size;
            s1_unsigned <= s_unsigned;
            s1_off      <= s0_off;
            s1_store    <= s_store;
            s1_err      <= s0_err;
        end
    end

    always_comb begin
        s1_byte = sram_rdata[{s1_off, 3'b000} +: 8];
        s1_half = sram_rdata[{s1_off[1], 4'b0000} +: 16];
        s1_data = 32'h0;
        if (!s1_store && !s1_err) begin
            case (s1_size)
                SZ_BYTE: s1_data = {{24{s1_byte[7] & ~s1_unsigned}}, s1_byte};
                SZ_HALF: s1_data = {{16{s1_half[15] & ~s1_unsigned}}, s1_half};
                SZ_WORD: s1_data = sram_rdata;
                default: s1_data = 32'h0;
            endcase
        end
    end

    // ---------------- Response FIFO ----------------
    logic [TAG_W-1:0] fifo_tag  [RESP_DEPTH];
    logic [31:0]      fifo_data [RESP_DEPTH];
    logic             fifo_err  [RESP_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign push = s1_vld && !flush;
    assign pop  = m_vld && m_rdy;

    always_ff @(posedge clk) begin
        if (rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_tag[wr_ptr]  <= s1_tag;
            fifo_data[wr_ptr] <= s1_data;
            fifo_err[wr_ptr]  <= s1_err;
        end
    end

    assign m_vld  = (cnt != '0);
    assign m_tag  = m_vld ? fifo_tag[rd_ptr]  : '0;
    assign m_data = m_vld ? fifo_data[rd_ptr] : 32'h0;
    assign m_err  = m_vld ? fifo_err[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_toy_lsu_dtcm_ctrl.sv
// Directed bench for toy_lsu_dtcm_ctrl: a small behavioural SRAM answers reads one cycle
// after the access; expected responses are hand-computed per vector.
module tb_toy_lsu_dtcm_ctrl;

    localparam int          ADDR_W  = 32;
    localparam int          TAG_W   = 6;
    localparam int          SRAM_AW = 12;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] BASE    = 32'h0010_0000;

    logic               clk;
    logic               rst_n;
    logic               flush;
    logic               s_vld;
    logic               s_rdy;
    logic [ADDR_W-1:0]  s_addr;
    logic               s_store;
    logic [1:0]         s_size;
    logic               s_unsigned;
    logic [31:0]        s_wdata;
    logic [TAG_W-1:0]   s_tag;
    logic               sram_en;
    logic               sram_we;
    logic [SRAM_AW-1:0] sram_addr;
    logic [3:0]         sram_wbe;
    logic [31:0]        sram_wdata;
    logic [31:0]        sram_rdata;
    logic               m_vld;
    logic               m_rdy;
    logic [TAG_W-1:0]   m_tag;
    logic [31:0]        m_data;
    logic               m_err;

    int n_cmp = 0;
    int n_bad = 0;

    toy_lsu_dtcm_ctrl #(
        .ADDR_W(ADDR_W), .TAG_W(TAG_W), .SRAM_AW(SRAM_AW),
        .DTCM_BASE(BASE), .RESP_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_vld(s_vld), .s_rdy(s_rdy), .s_addr(s_addr), .s_store(s_store),
        .s_size(s_size), .s_unsigned(s_unsigned), .s_wdata(s_wdata), .s_tag(s_tag),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wbe(sram_wbe), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .m_vld(m_vld), .m_rdy(m_rdy), .m_tag(m_tag), .m_data(m_data), .m_err(m_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 16-word SRAM, 1-cycle read latency, byte-lane writes.
    logic [31:0] mem [16] = '{
        32'h8000_0000, 32'hAAAA_AAAA, 32'hDEAD_BEEF, 32'h0000_0000,
        32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777,
        32'h8888_8888, 32'h9999_9999, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000
    };

    always @(posedge clk) begin
        if (sram_en && !sram_we) sram_rdata <= mem[sram_addr[3:0]];
        if (sram_en && sram_we) begin
            for (int b = 0; b < 4; b++)
                if (sram_wbe[b]) mem[sram_addr[3:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end

    // Response log, sampled mid-cycle when a handshake is about to complete.
    logic [TAG_W-1:0] q_tag  [$];
    logic [31:0]      q_data [$];

    always @(negedge clk) begin
        if (m_vld && m_rdy) begin
            q_tag.push_back(m_tag);
            q_data.push_back(m_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic st, input logic [1:0] sz,
                             input logic uns, input logic [31:0] wd, input logic [TAG_W-1:0] tg);
        s_vld      = 1'b1;
        s_addr     = addr;
        s_store    = st;
        s_size     = sz;
        s_unsigned = uns;
        s_wdata    = wd;
        s_tag      = tg;
        #1;
    endtask

    // Hold the request until accepted (bounded), then drop s_vld just after the accepting edge.
    task automatic finish_req(input string name);
        bit done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (s_rdy) done = 1;
            tick();
        end
        s_vld = 1'b0;
        if (!done) check({name, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    // Called in cycle T+1: response must be absent now and present at T+2.
    task automatic expect_rsp(input string name, input logic [TAG_W-1:0] tg,
                              input logic [31:0] data, input logic err);
        check({name, "_vld_t1"}, m_vld, 1'b0);
        tick();
        check({name, "_vld_t2"}, m_vld, 1'b1);
        check({name, "_tag"}, m_tag, tg);
        check({name, "_data"}, m_data, data);
        check({name, "_err"}, m_err, err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit drained;

        rst_n = 1'b1; flush = 1'b0; s_vld = 1'b0; m_rdy = 1'b1;
        s_addr = '0; s_store = 1'b0; s_size = 2'b00; s_unsigned = 1'b0; s_wdata = '0; s_tag = '0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("rst_s_rdy", s_rdy, 1'b1);
        check("rst_m_vld", m_vld, 1'b0);
        check("rst_sram_en", sram_en, 1'b0);
        check("rst_m_tag", m_tag, '0);
        check("rst_m_data", m_data, 32'h0);
        check("rst_m_err", m_err, 1'b0);
        tick();

        // Word load, aligned.
        drive_req(32'h0010_0008, 1'b0, 2'b10, 1'b0, 32'h0, 6'd5);
        check("wld_en", sram_en, 1'b1);
        check("wld_we", sram_we, 1'b0);
        check("wld_addr", sram_addr, 32'd2);
        finish_req("wld");
        expect_rsp("wld", 6'd5, 32'hDEAD_BEEF, 1'b0);
        tick();

        // Byte loads from lane 3, signed then unsigned.
        drive_req(32'h0010_0003, 1'b0, 2'b00, 1'b0, 32'h0, 6'd6);
        check("sbld_addr", sram_addr, 32'd0);
        finish_req("sbld");
        expect_rsp("sbld", 6'd6, 32'hFFFF_FF80, 1'b0);
        tick();
        drive_req(32'h0010_0003, 1'b0, 2'b00, 1'b1, 32'h0, 6'd7);
        finish_req("ubld");
        expect_rsp("ubld", 6'd7, 32'h0000_0080, 1'b0);
        tick();

        // Half store to upper lanes, then read back the merged word and a signed half.
        drive_req(32'h0010_0006, 1'b1, 2'b01, 1'b0, 32'h0000_1234, 6'd8);
        check("hst_en", sram_en, 1'b1);
        check("hst_we", sram_we, 1'b1);
        check("hst_addr", sram_addr, 32'd1);
        check("hst_wbe", sram_wbe, 4'b1100);
        check("hst_wdata", sram_wdata, 32'h1234_1234);
        finish_req("hst");
        expect_rsp("hst", 6'd8, 32'h0, 1'b0);
        tick();
        drive_req(32'h0010_0004, 1'b0, 2'b10, 1'b0, 32'h0, 6'd9);
        finish_req("rdbk");
        expect_rsp("rdbk", 6'd9, 32'h1234_AAAA, 1'b0);
        tick();
        drive_req(32'h0010_0004, 1'b0, 2'b01, 1'b0, 32'h0, 6'd11);
        finish_req("shld");
        expect_rsp("shld", 6'd11, 32'hFFFF_AAAA, 1'b0);
        tick();

        // Byte store to lane 1.
        drive_req(32'h0010_0001, 1'b1, 2'b00, 1'b0, 32'h0000_00AB, 6'd12);
        check("bst_wbe", sram_wbe, 4'b0010);
        check("bst_wdata", sram_wdata, 32'hABAB_ABAB);
        finish_req("bst");
        expect_rsp("bst", 6'd12, 32'h0, 1'b0);
        tick();

        // Misaligned word and illegal size: no SRAM access, error response.
        drive_req(32'h0010_0002, 1'b0, 2'b10, 1'b0, 32'h0, 6'd10);
        check("mis_en", sram_en, 1'b0);
        finish_req("mis");
        expect_rsp("mis", 6'd10, 32'h0, 1'b1);
        tick();
        drive_req(32'h0010_0000, 1'b0, 2'b11, 1'b0, 32'h0, 6'd13);
        check("ill_en", sram_en, 1'b0);
        finish_req("ill");
        expect_rsp("ill", 6'd13, 32'h0, 1'b1);
        tick();

        // Backpressure: six back-to-back loads with m_rdy low, then drain in order.
        q_tag.delete();
        q_data.delete();
        m_rdy = 1'b0;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            drive_req(BASE + 32'(4 * (4 + k)), 1'b0, 2'b10, 1'b0, 32'h0, 6'(20 + k));
            if (s_rdy) k++;
            tick();
        end
        check("bp_accepted", 32'(k), 32'd4);
        check("bp_s_rdy", s_rdy, 1'b0);
        check("bp_m_vld", m_vld, 1'b1);
        check("bp_head_tag", m_tag, 6'd20);
        tick();
        check("bp_head_hold", m_tag, 6'd20);
        m_rdy = 1'b1;
        drained = 0;
        for (int c = 0; c < 40 && !drained; c++) begin
            if (k < 6) begin
                drive_req(BASE + 32'(4 * (4 + k)), 1'b0, 2'b10, 1'b0, 32'h0, 6'(20 + k));
                if (s_rdy) k++;
            end else begin
                s_vld = 1'b0;
                #1;
            end
            tick();
            if (q_tag.size() >= 6) drained = 1;
        end
        s_vld = 1'b0;
        check("bp_rsp_count", 32'(q_tag.size()), 32'd6);
        for (int i = 0; i < 6 && i < q_tag.size(); i++) begin
            check($sformatf("bp_tag%0d", i), q_tag[i], 6'(20 + i));
            check($sformatf("bp_data%0d", i), q_data[i], 32'h1111_1111 * (4 + i));
        end
        tick();
        check("bp_empty", m_vld, 1'b0);

        // Flush with one request in S1 and two queued.
        m_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_req(BASE + 32'(4 * (4 + i)), 1'b0, 2'b10, 1'b0, 32'h0, 6'(30 + i));
            check($sformatf("fl_rdy%0d", i), s_rdy, 1'b1);
            tick();
        end
        s_vld = 1'b0;
        flush = 1'b1;
        #1;
        check("fl_s_rdy_during", s_rdy, 1'b0);
        check("fl_m_vld_before", m_vld, 1'b1);
        tick();
        flush = 1'b0;
        #1;
        check("fl_m_vld_after", m_vld, 1'b0);
        check("fl_s_rdy_after", s_rdy, 1'b1);
        tick();
        check("fl_no_s1_push", m_vld, 1'b0);
        m_rdy = 1'b1;
        drive_req(32'h0010_0008, 1'b0, 2'b10, 1'b0, 32'h0, 6'd33);
        finish_req("fl_new");
        expect_rsp("fl_new", 6'd33, 32'hDEAD_BEEF, 1'b0);
        tick();
        check("fl_no_stale", m_vld, 1'b0);

        // Reset in the middle of a drain.
        for (int i = 0; i < 3; i++) begin
            drive_req(BASE + 32'(4 * (4 + i)), 1'b0, 2'b10, 1'b0, 32'h0, 6'(40 + i));
            tick();
        end
        s_vld = 1'b0;
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        check("rd_m_vld", m_vld, 1'b0);
        check("rd_m_tag", m_tag, '0);
        check("rd_m_data", m_data, 32'h0);
        check("rd_s_rdy", s_rdy, 1'b1);
        tick();
        check("rd_no_s1_push", m_vld, 1'b0);
        drive_req(32'h0010_0003, 1'b0, 2'b00, 1'b1, 32'h0, 6'd43);
        finish_req("rd_new");
        expect_rsp("rd_new", 6'd43, 32'h0000_0080, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
